// File: rtl/fq_pkg.sv
// Shared types for the match scoreboard: FSM states, winner codes and goal
// counter width.
package fq_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAYING    = 2'd1,
    GOAL_PAUSE = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_T1   = 2'b01;
  localparam logic [1:0] WIN_T2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int GOAL_W = 4;

  function automatic logic [1:0] winner_of(input logic [GOAL_W-1:0] a,
                                           input logic [GOAL_W-1:0] b);
    if (a > b)      return WIN_T1;
    else if (a < b) return WIN_T2;
    else            return WIN_DRAW;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector producing a one-cycle pulse; SYNC=1 adds a 2-flop
// synchronizer in front for inputs that are asynchronous to clk.
module edge_detect #(
  parameter bit SYNC = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic d_s;
  logic d_prev;

  generate
    if (SYNC) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], d};
      end
      assign d_s = sync_q[1];
    end else begin : g_raw
      assign d_s = d;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_prev <= 1'b0;
    else        d_prev <= d_s;
  end

  assign pulse = d_s & ~d_prev;

endmodule

// File: rtl/match_scoreboard.sv
// Match clock and score keeper: counts down seconds, tallies goals, freezes
// play during goal pauses and after full time, and reports the winner.
module match_scoreboard
  import fq_pkg::*;
#(
  parameter int CLK_FREQ           = 50_000_000,
  parameter int MATCH_SECONDS      = 90,
  parameter int GOAL_PAUSE_SECONDS = 2,
  parameter int SCORE_LIMIT        = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_button,
  input  logic              team1_score,
  input  logic              team2_score,
  output logic [7:0]        time_left,
  output logic [GOAL_W-1:0] team1_goals,
  output logic [GOAL_W-1:0] team2_goals,
  output logic              game_active,
  output logic              game_over,
  output logic [1:0]        winner,
  output logic              second_tick,
  output state_t            state_dbg
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]     PRESC_MAX  = PW'(CLK_FREQ - 1);
  localparam logic [7:0]        TL_INIT    = 8'(MATCH_SECONDS);
  localparam logic [7:0]        PAUSE_INIT = 8'(GOAL_PAUSE_SECONDS);
  localparam logic [GOAL_W-1:0] LIMIT      = GOAL_W'(SCORE_LIMIT);

  logic start_ev, t1_ev, t2_ev;

  edge_detect #(.SYNC(1'b1)) u_start (
    .clk(clk), .rst_n(rst_n), .d(start_button), .pulse(start_ev)
  );
  edge_detect #(.SYNC(1'b0)) u_team1 (
    .clk(clk), .rst_n(rst_n), .d(team1_score), .pulse(t1_ev)
  );
  edge_detect #(.SYNC(1'b0)) u_team2 (
    .clk(clk), .rst_n(rst_n), .d(team2_score), .pulse(t2_ev)
  );

  state_t            state_q, state_n;
  logic [PW-1:0]     presc_q, presc_n;
  logic [7:0]        pause_q, pause_n;
  logic [7:0]        time_q, time_n;
  logic [GOAL_W-1:0] g1_q, g1_n, g2_q, g2_n;
  logic [1:0]        winner_q, winner_n;
  logic              tick_q, tick_n;
  logic              counting, wrap;

  assign counting = (state_q == PLAYING) || (state_q == GOAL_PAUSE);
  assign wrap     = counting && (presc_q == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      pause_q  <= '0;
      time_q   <= TL_INIT;
      g1_q     <= '0;
      g2_q     <= '0;
      winner_q <= WIN_NONE;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      presc_q  <= presc_n;
      pause_q  <= pause_n;
      time_q   <= time_n;
      g1_q     <= g1_n;
      g2_q     <= g2_n;
      winner_q <= winner_n;
      tick_q   <= tick_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    presc_n  = presc_q;
    pause_n  = pause_q;
    time_n   = time_q;
    g1_n     = g1_q;
    g2_n     = g2_q;
    winner_n = winner_q;
    tick_n   = wrap;

    if (counting) presc_n = wrap ? '0 : presc_q + PW'(1);

    case (state_q)
      IDLE: begin
        presc_n  = '0;
        pause_n  = '0;
        time_n   = TL_INIT;
        g1_n     = '0;
        g2_n     = '0;
        winner_n = WIN_NONE;
        if (start_ev) state_n = PLAYING;
      end

      PLAYING: begin
        if (wrap && (time_q != 8'd0)) time_n = time_q - 8'd1;
        if (t1_ev && (g1_q != LIMIT)) g1_n = g1_q + GOAL_W'(1);
        if (t2_ev && (g2_q != LIMIT)) g2_n = g2_q + GOAL_W'(1);
        // Full time outranks the score limit, which outranks a goal pause;
        // a goal on the final tick is therefore counted before game over.
        if (wrap && (time_n == 8'd0)) begin
          state_n  = GAME_OVER;
          winner_n = winner_of(g1_n, g2_n);
        end else if ((g1_n == LIMIT) || (g2_n == LIMIT)) begin
          state_n  = GAME_OVER;
          winner_n = winner_of(g1_n, g2_n);
        end else if (t1_ev || t2_ev) begin
          state_n = GOAL_PAUSE;
          pause_n = PAUSE_INIT;
        end
      end

      GOAL_PAUSE: begin
        if (wrap) begin
          if (pause_q > 8'd1) begin
            pause_n = pause_q - 8'd1;
          end else begin
            pause_n = '0;
            state_n = PLAYING;
          end
        end
      end

      GAME_OVER: begin
        presc_n = '0;
        if (start_ev) begin
          state_n  = IDLE;
          time_n   = TL_INIT;
          g1_n     = '0;
          g2_n     = '0;
          winner_n = WIN_NONE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign time_left   = time_q;
  assign team1_goals = g1_q;
  assign team2_goals = g2_q;
  assign game_active = (state_q == PLAYING);
  assign game_over   = (state_q == GAME_OVER);
  assign winner      = winner_q;
  assign second_tick = tick_q;
  assign state_dbg   = state_q;

endmodule
